fetch_sequencer: RTL and testbench

Controls the fetch stage: generates instruction-memory requests, holds the address stable until ihit, selects the next PC (sequential, predicted-taken, or flush redirect) and buffers fetched instructions in a small FIFO toward dispatch. It sits between the I-memory port and the fetch/branch datapath. It consumes flush/stall/dispatch_free/predicted_outcome and produces the instr/pc pair that the fetch_branch datapath consumes.

---
 rtl/fetch_sequencer.sv | 150 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Fetch-stage controller. Issues I-memory reads, keeps the request address
// stable until ihit, chooses the next fetch PC (sequential, predicted-taken or
// flush redirect) and queues fetched instructions toward dispatch.
//
// Ports:
//   CLK, nRST          clock (rising edge), asynchronous active-low reset
//   imemREN, imemaddr  I-memory read request and address
//   ihit, imemload     I-memory completion and returned instruction
//   flush, flush_pc    redirect: drop buffered and in-flight work, refetch at flush_pc
//   stall              blocks issue of new requests (never blocks dispatch)
//   predicted_outcome, predicted_target  prediction for the returning instruction
//   dispatch_free      downstream accepts the head entry this cycle
//   instr, pc, pred_taken, instr_valid   head entry of the instruction buffer
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        stall,
  input  logic        predicted_outcome,
  input  logic [31:0] predicted_target,
  input  logic        dispatch_free,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        instr_valid,
  output logic        pred_taken
);

  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state;
  logic [31:0]        fetch_pc;
  logic [31:0]        drain_addr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  logic [31:0]        instr_mem [BUF_DEPTH];
  logic [31:0]        pc_mem    [BUF_DEPTH];
  logic               pt_mem    [BUF_DEPTH];

  logic               can_issue;
  logic               push;
  logic               pop;
  logic [31:0]        next_pc;

  // Request generation and buffer handshakes
  always_comb begin
    can_issue = !stall && !flush && (count < CNT_W'(BUF_DEPTH));
    imemREN   = 1'b0;
    imemaddr  = fetch_pc;
    case (state)
      IDLE:    imemREN = can_issue;
      REQ:     imemREN = 1'b1;
      DRAIN: begin
        imemREN  = 1'b1;
        imemaddr = drain_addr;
      end
      default: imemREN = 1'b0;
    endcase
    // Reset drops any request at once, even though the state is combinationally IDLE
    imemREN = imemREN && nRST;
    // Data returning for a drained (pre-flush) request is never buffered
    push    = imemREN && ihit && !flush && (state != DRAIN);
    pop     = (count != '0) && dispatch_free && !flush;
    next_pc = predicted_outcome ? predicted_target : fetch_pc + 32'd4;
  end

  // Control state, fetch PC and buffer pointers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      drain_addr <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      fetch_pc <= flush_pc;
      // An outstanding request must still complete at its original address
      if ((state == REQ || state == DRAIN) && !ihit) begin
        state <= DRAIN;
        if (state == REQ) drain_addr <= fetch_pc;
      end else begin
        state <= IDLE;
      end
    end else begin
      case (state)
        IDLE: begin
          if (push)         fetch_pc <= next_pc;
          else if (imemREN) state    <= REQ;
        end
        REQ: begin
          if (ihit) begin
            fetch_pc <= next_pc;
            state    <= IDLE;
          end
        end
        DRAIN: begin
          if (ihit) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (push) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
      if (pop)  rd_ptr <= PTR_W'(rd_ptr + 1'b1);
      case ({push, pop})
        2'b10:   count <= CNT_W'(count + 1'b1);
        2'b01:   count <= CNT_W'(count - 1'b1);
        default: count <= count;
      endcase
    end
  end

  // Buffer storage; contents are only observed through count, so no reset needed
  always_ff @(posedge CLK) begin
    if (push) begin
      instr_mem[wr_ptr] <= imemload;
      pc_mem[wr_ptr]    <= fetch_pc;
      pt_mem[wr_ptr]    <= predicted_outcome;
    end
  end

  // Head entry presented directly; zeros when empty
  always_comb begin
    instr_valid = (count != '0);
    instr       = instr_valid ? instr_mem[rd_ptr] : 32'd0;
    pc          = instr_valid ? pc_mem[rd_ptr]    : 32'd0;
    pred_taken  = instr_valid ? pt_mem[rd_ptr]    : 1'b0;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios with literal
// expectations, then randomized traffic checked against a queue-based model.
module tb_fetch_sequencer;

  localparam int unsigned DEPTH = 2;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        flush;
  logic [31:0] flush_pc;
  logic        stall;
  logic        predicted_outcome;
  logic [31:0] predicted_target;
  logic        dispatch_free;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        instr_valid;
  logic        pred_taken;

  fetch_sequencer #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(DEPTH)) dut (
    .CLK(CLK), .nRST(nRST),
    .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload),
    .flush(flush), .flush_pc(flush_pc),
    .stall(stall),
    .predicted_outcome(predicted_outcome), .predicted_target(predicted_target),
    .dispatch_free(dispatch_free),
    .instr(instr), .pc(pc), .instr_valid(instr_valid), .pred_taken(pred_taken)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Behavioural model: buffer as a queue, plus fetch PC and request status
  typedef struct {
    logic [31:0] i;
    logic [31:0] p;
    logic        t;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc;
  bit          m_outstanding;
  bit          m_draining;
  logic [31:0] m_held;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc          = 32'h0;
    m_outstanding = 0;
    m_draining    = 0;
    m_held        = 32'h0;
  endtask

  function automatic bit exp_ren();
    return m_draining || m_outstanding || (!stall && !flush && q.size() < DEPTH);
  endfunction

  // Compare every DUT output against the model for the current inputs
  task automatic compare_model();
    ent_t h;
    h = '{i: 32'h0, p: 32'h0, t: 1'b0};
    if (q.size() > 0) h = q[0];
    chk("imemREN",     32'(imemREN),     32'(exp_ren()));
    chk("imemaddr",    imemaddr,         m_draining ? m_held : m_pc);
    chk("instr_valid", 32'(instr_valid), 32'(q.size() > 0));
    chk("instr",       instr,            h.i);
    chk("pc",          pc,               h.p);
    chk("pred_taken",  32'(pred_taken),  32'(h.t));
  endtask

  // Advance the model by one clock using the inputs applied this cycle
  task automatic model_update();
    bit ren;
    bit do_pop;
    ren    = exp_ren();
    do_pop = (q.size() > 0) && dispatch_free;
    if (flush) begin
      q.delete();
      if ((m_outstanding || m_draining) && !ihit) begin
        if (!m_draining) m_held = m_pc;
        m_draining = 1;
      end else begin
        m_draining = 0;
      end
      m_outstanding = 0;
      m_pc          = flush_pc;
    end else begin
      if (do_pop) void'(q.pop_front());
      if (m_draining) begin
        if (ihit) m_draining = 0;
      end else if (ren) begin
        if (ihit) begin
          q.push_back('{i: imemload, p: m_pc, t: predicted_outcome});
          m_pc          = predicted_outcome ? predicted_target : m_pc + 32'd4;
          m_outstanding = 0;
        end else begin
          m_outstanding = 1;
        end
      end
    end
  endtask

  task automatic drive(input bit i_stall, input bit i_flush, input logic [31:0] i_fpc,
                       input bit i_ihit, input logic [31:0] i_load, input bit i_po,
                       input logic [31:0] i_pt, input bit i_df);
    @(negedge CLK);
    stall             = i_stall;
    flush             = i_flush;
    flush_pc          = i_fpc;
    ihit              = i_ihit;
    imemload          = i_load;
    predicted_outcome = i_po;
    predicted_target  = i_pt;
    dispatch_free     = i_df;
    #1;
    compare_model();
  endtask

  task automatic commit();
    @(posedge CLK);
    model_update();
  endtask

  initial begin
    nRST = 1'b0;
    stall = 0; flush = 0; flush_pc = 0; ihit = 0; imemload = 0;
    predicted_outcome = 0; predicted_target = 0; dispatch_free = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #1;
    chk("rst_imemREN", 32'(imemREN), 32'd0);
    chk("rst_valid",   32'(instr_valid), 32'd0);
    chk("rst_instr",   instr, 32'd0);
    chk("rst_pc",      pc, 32'd0);
    chk("rst_pt",      32'(pred_taken), 32'd0);
    @(posedge CLK);
    #2 nRST = 1'b1;

    // Back-to-back fetch with ihit in the issue cycle
    drive(0, 0, 0, 1, 32'hA000_0000, 0, 0, 1);
    chk("seq_addr0", imemaddr, 32'h0); chk("seq_valid0", 32'(instr_valid), 32'd0);
    commit();
    drive(0, 0, 0, 1, 32'hA000_0004, 0, 0, 1);
    chk("seq_addr4", imemaddr, 32'h4); chk("seq_pc0", pc, 32'h0);
    chk("seq_instr0", instr, 32'hA000_0000);
    commit();
    drive(0, 0, 0, 1, 32'hA000_0008, 0, 0, 1);
    chk("seq_addr8", imemaddr, 32'h8); chk("seq_pc4", pc, 32'h4);
    commit();
    drive(0, 0, 0, 0, 32'h0, 0, 0, 1);
    chk("seq_addrC", imemaddr, 32'hC); chk("seq_pc8", pc, 32'h8);
    chk("seq_instr8", instr, 32'hA000_0008);
    commit();

    // Flush during an outstanding request: drain old address, then redirect
    drive(0, 1, 32'hFFFF_FFFC, 0, 32'h0, 0, 0, 0);
    commit();
    drive(0, 0, 0, 1, 32'hDEAD_0000, 0, 0, 1);
    chk("drain_addr", imemaddr, 32'hC); chk("drain_valid", 32'(instr_valid), 32'd0);
    commit();
    drive(0, 0, 0, 1, 32'hB000_0000, 0, 0, 0);
    chk("redir_addr", imemaddr, 32'hFFFF_FFFC); chk("drop_valid", 32'(instr_valid), 32'd0);
    commit();
    drive(0, 0, 0, 0, 32'h0, 0, 0, 0);
    chk("wrap_addr", imemaddr, 32'h0); chk("wrap_pc", pc, 32'hFFFF_FFFC);
    commit();
    // Flush coinciding with ihit: returned data discarded
    drive(0, 1, 32'h200, 1, 32'hBAD0_0000, 0, 0, 1);
    commit();
    drive(0, 0, 0, 0, 32'h0, 0, 0, 0);
    chk("fl_ihit_addr", imemaddr, 32'h200); chk("fl_ihit_valid", 32'(instr_valid), 32'd0);
    commit();
    drive(0, 1, 32'h100, 0, 32'h0, 0, 0, 0);
    commit();
    drive(1, 0, 0, 0, 32'h0, 0, 0, 0);
    chk("drain2_ren", 32'(imemREN), 32'd1); chk("drain2_addr", imemaddr, 32'h200);
    commit();
    drive(1, 0, 0, 1, 32'hBAD1_0000, 0, 0, 0);
    commit();
    drive(1, 0, 0, 0, 32'h0, 0, 0, 0);
    chk("stall_ren", 32'(imemREN), 32'd0); chk("post_drain_addr", imemaddr, 32'h100);
    commit();

    // Predicted-taken redirect, then fill the buffer
    drive(0, 0, 0, 1, 32'hC000_0100, 1, 32'h40, 0);
    commit();
    drive(1, 0, 0, 0, 32'h0, 0, 0, 0);
    chk("pred_addr", imemaddr, 32'h40); chk("pred_bit", 32'(pred_taken), 32'd1);
    commit();
    drive(0, 0, 0, 1, 32'hC000_0040, 0, 0, 0);
    commit();
    drive(0, 0, 0, 1, 32'h0, 0, 0, 0);
    chk("full_ren", 32'(imemREN), 32'd0);
    commit();
    drive(0, 0, 0, 1, 32'h0, 0, 0, 1);
    chk("full_pop_ren", 32'(imemREN), 32'd0);
    commit();
    drive(0, 0, 0, 0, 32'h0, 0, 0, 0);
    chk("after_pop_ren", 32'(imemREN), 32'd1); chk("after_pop_addr", imemaddr, 32'h44);
    commit();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 3) == 0,
            $urandom_range(0, 19) == 0,
            {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
            $urandom_range(0, 2) != 0,
            $urandom,
            $urandom_range(0, 3) == 0,
            {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
            $urandom_range(0, 2) != 0);
      commit();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
